seq_mult_ctrl: RTL
==================

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  algorithm select, sampled with start: 0 = repeated addition, 1 = shift-and-add.
REQ-006 SHALL have port a_in  input  W  multiplicand, sampled with start.
REQ-007 SHALL have port b_in  input  W  multiplier, sampled with start.
REQ-008 SHALL have port product  output  2W  registered result of the last completed operation.
REQ-009 SHALL have port busy  output  1  high while an operation is in RUN.
REQ-010 SHALL have port done  output  1  registered one-cycle completion pulse.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and RUN, with internal registers acc (2W), areg (2W), breg (W) and mreg (1).
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL latch areg={W'0,a_in}, breg=b_in, mreg=mode, clear acc to 0, set busy=1 and move to RUN (the acceptance edge).
REQ-013 In IDLE with start=0, the block SHALL hold all registers.
REQ-014 In RUN with breg==0, at the next edge the block SHALL load product=acc, pulse done=1, clear busy and return to IDLE.
REQ-015 In RUN with breg!=0 and mreg=0, each edge SHALL perform acc=acc+areg and breg=breg-1.
REQ-016 In RUN with breg!=0 and mreg=1, each edge SHALL add areg to acc if breg[0]=1, then shift areg left by 1 and shift breg right by 1.
REQ-017 All arithmetic SHALL be unsigned and 2W wide; no overflow is possible and no saturation or flag is provided.
REQ-018 For mode 0, done SHALL assert b_in+1 cycles after the acceptance edge.
REQ-019 For mode 1, done SHALL assert L+1 cycles after the acceptance edge, where L is the bit-length of b_in (L=0 for b_in=0).
REQ-020 The b_in=0 case SHALL complete after 1 cycle with product=0 in either mode; the a_in=0 case SHALL run the full latency and yield product=0.
REQ-021 start SHALL be ignored while in RUN; operands, mode and the in-flight result SHALL be unaffected.
REQ-022 done SHALL be high for exactly one cycle and SHALL be low at every other time.
REQ-023 product SHALL change only on the completion edge, holding the previous result throughout RUN.
REQ-024 start high in the cycle where done=1 (state IDLE) SHALL be accepted at that edge, giving back-to-back operation with no dead cycle.
REQ-025 busy and done SHALL never be high simultaneously.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force state=IDLE and clear product, acc, areg, breg, mreg, busy and done to 0.
REQ-027 Reset asserted during RUN SHALL abort the operation with no done pulse; product SHALL read 0 after reset.
REQ-028 After rst_n deasserts, the first edge SHALL behave per IDLE rules; start high at that edge SHALL be accepted.

Verification
REQ-029 W=8, mode=0, a=5, b=3 -> busy high for 4 cycles, done pulses 4 cycles after acceptance, product=15.
REQ-030 W=8, mode=1, a=255, b=255 -> done after 9 cycles, product=65025; mode=0 with the same operands -> done after 256 cycles, product=65025.
REQ-031 b=0 (both modes, a=77) -> done after 1 cycle, product=0; a=0, b=200, mode=0 -> done after 201 cycles, product=0.
REQ-032 Accept a=6, b=7, mode=1; then hold start=1 with a=9, b=9 throughout RUN -> first done gives product=42, the next edge accepts 9x9, and the following done gives product=81.
REQ-033 Accept a=10, b=50, mode=0; pulse rst_n low after 20 cycles, asynchronously -> busy, done and product become 0 immediately, no done pulse follows; the next op (a=3, b=4) gives product=12.
REQ-034 W=16, mode=1, a=0xFFFF, b=0x8001 -> done after 17 cycles, product=0x8000_7FFF; product holds its previous value until the completion edge.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
// Sequential unsigned W x W multiplier with two selectable algorithms:
//   mode 0 : repeated addition (b_in iterations)
//   mode 1 : shift-and-add (one iteration per significant bit of b_in)
// A two-state FSM (IDLE/RUN) accepts an operation when start is high in
// IDLE, iterates in RUN until the multiplier register is exhausted, then
// publishes the result on product with a one-cycle done pulse.
//
// Ports
//   clk      in   1    rising-edge clock
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    operation request, only looked at in IDLE
//   mode     in   1    algorithm select, captured with start
//   a_in     in   W    multiplicand, captured with start
//   b_in     in   W    multiplier, captured with start
//   product  out  2W   result of the last completed operation (registered)
//   busy     out  1    high while the FSM is in RUN
//   done     out  1    one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module seq_mult_ctrl #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic [2*W-1:0]   product,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [2*W-1:0]   r_acc;
  logic [2*W-1:0]   r_areg;
  logic [W-1:0]     r_breg;
  logic             r_mreg;
  logic [2*W-1:0]   r_product;
  logic             r_busy;
  logic             r_done;

  logic [2*W-1:0]   w_acc_nxt;
  logic [2*W-1:0]   w_areg_nxt;
  logic [W-1:0]     w_breg_nxt;
  logic             w_mreg_nxt;
  logic [2*W-1:0]   w_product_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // State register plus all datapath / output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_areg    <= '0;
      r_breg    <= '0;
      r_mreg    <= 1'b0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_areg    <= w_areg_nxt;
      r_breg    <= w_breg_nxt;
      r_mreg    <= w_mreg_nxt;
      r_product <= w_product_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start)          w_state_nxt = S_RUN;
      S_RUN:  if (r_breg == '0)   w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    w_acc_nxt     = r_acc;
    w_areg_nxt    = r_areg;
    w_breg_nxt    = r_breg;
    w_mreg_nxt    = r_mreg;
    w_product_nxt = r_product;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;           // done is a pulse: low unless completing
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_areg_nxt = {{W{1'b0}}, a_in};
          w_breg_nxt = b_in;
          w_mreg_nxt = mode;
          w_acc_nxt  = '0;
          w_busy_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (r_breg == '0) begin
          // Multiplier exhausted: publish result in the same edge busy drops
          w_product_nxt = r_acc;
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
        end else if (!r_mreg) begin
          w_acc_nxt  = r_acc + r_areg;
          w_breg_nxt = r_breg - W'(1);
        end else begin
          if (r_breg[0]) w_acc_nxt = r_acc + r_areg;
          // areg is 2W wide, so shifting up to W times never loses bits
          w_areg_nxt = r_areg << 1;
          w_breg_nxt = r_breg >> 1;
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign product = r_product;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
